// File: rtl/hero_write_packer.sv
// Store-and-forward packer for the hero write bus: buffers whole transactions in a FIFO
// and replays each as a gap-free VALID* DONE burst on a registered bus.
module hero_write_packer #(
    parameter int unsigned HERO_WIDTH = 36,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [HERO_WIDTH-1:0]   in_data,
    input  logic                    in_last,
    output logic [HERO_WIDTH+4:0]   hero_out,
    output logic [$clog2(DEPTH):0]  txn_pending,
    output logic                    trunc_err,
    input  logic                    clr_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [3:0] CT_IDLE  = 4'd0;
    localparam logic [3:0] CT_VALID = 4'd1;
    localparam logic [3:0] CT_DONE  = 4'd2;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [HERO_WIDTH-1:0] r_data_mem [DEPTH];
    logic [DEPTH-1:0]      r_last_mem;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_pending;
    logic                  r_err;
    logic                  r_live;
    logic [HERO_WIDTH+4:0] r_hero;
    state_t                r_state;
    state_t                w_state_d;

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_start;
    logic                  w_trunc;
    logic                  w_inc;
    logic                  w_head_last;
    logic [HERO_WIDTH-1:0] w_head_data;
    logic [3:0]            w_type;
    logic [HERO_WIDTH-1:0] w_wdat;

    assign w_full      = (r_count == CW'(DEPTH));
    // r_live holds ready low for the first cycle after reset is released.
    assign in_ready    = rst_n && r_live && !w_full;
    assign w_push      = in_valid && in_ready;
    assign w_head_data = r_data_mem[r_rd_ptr];
    assign w_head_last = r_last_mem[r_rd_ptr];

    // Idle with a full FIFO and no buffered last beat can never drain: close the transaction.
    assign w_trunc = (r_state == S_IDLE) && w_full && (r_pending == '0);
    assign w_inc   = (w_push && in_last) || w_trunc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        w_start   = 1'b0;
        w_type    = CT_IDLE;
        w_wdat    = '0;
        unique case (r_state)
            S_IDLE: begin
                if (r_pending != '0) begin
                    w_pop     = 1'b1;
                    w_start   = 1'b1;
                    w_type    = w_head_last ? CT_DONE : CT_VALID;
                    w_wdat    = w_head_data;
                    w_state_d = w_head_last ? S_IDLE : S_SEND;
                end
            end
            S_SEND: begin
                w_pop     = 1'b1;
                w_type    = w_head_last ? CT_DONE : CT_VALID;
                w_wdat    = w_head_data;
                w_state_d = w_head_last ? S_IDLE : S_SEND;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= in_data;
            r_last_mem[r_wr_ptr] <= in_last;
        end
        if (w_trunc) begin
            r_last_mem[r_wr_ptr - AW'(1)] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pending <= '0;
            r_err     <= 1'b0;
            r_live    <= 1'b0;
            r_hero    <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count   <= r_count + CW'(w_push) - CW'(w_pop);
            r_pending <= r_pending + CW'(w_inc) - CW'(w_start);
            if (w_trunc) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end
            r_hero <= {w_type, w_wdat, (w_type != CT_IDLE)};
        end
    end

    assign hero_out    = r_hero;
    assign txn_pending = r_pending;
    assign trunc_err   = r_err;

endmodule

// File: tb/tb_hero_write_packer.sv
// Bench for hero_write_packer: directed timing scenarios plus a randomized run checked
// against a queue scoreboard of accepted beats.
module tb_hero_write_packer;
    localparam int unsigned HW    = 36;
    localparam int unsigned DEPTH = 8;
    localparam logic [3:0]  IDLE  = 4'd0;
    localparam logic [3:0]  VALID = 4'd1;
    localparam logic [3:0]  DONE  = 4'd2;

    logic                   clk      = 1'b0;
    logic                   rst_n    = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [HW-1:0]          in_data  = '0;
    logic                   in_last  = 1'b0;
    logic [HW+4:0]          hero_out;
    logic [$clog2(DEPTH):0] txn_pending;
    logic                   trunc_err;
    logic                   clr_err  = 1'b0;

    logic [3:0]             ct;
    logic [HW-1:0]          wd;
    logic                   ce;

    int n_vec = 0;
    int n_err = 0;

    assign ct = hero_out[HW+4:HW+1];
    assign wd = hero_out[HW:1];
    assign ce = hero_out[0];

    always #5 clk = ~clk;

    hero_write_packer #(
        .HERO_WIDTH(HW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .hero_out   (hero_out),
        .txn_pending(txn_pending),
        .trunc_err  (trunc_err),
        .clr_err    (clr_err)
    );

    function automatic logic [HW-1:0] rnd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[HW-1:0];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (hero_out !== '0) begin
            n_err++; $display("FAIL reset_bus: got %h want 0", hero_out);
        end
        n_vec++;
        if (txn_pending !== '0) begin
            n_err++; $display("FAIL reset_pending: got %0d want 0", txn_pending);
        end
        n_vec++;
        if (trunc_err !== 1'b0) begin
            n_err++; $display("FAIL reset_trunc_err: got %b want 0", trunc_err);
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready_low: got %b want 0", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready_high: got %b want 1", in_ready);
        end
    endtask

    // Stream s[] is expected on the bus starting at cycle 'first', in order.
    task automatic test_basic();
        logic [HW-1:0] s [3];
        logic [3:0]    et;
        logic [HW-1:0] ed;
        for (int i = 0; i < 3; i++) s[i] = rnd();
        for (int k = 0; k < 8; k++) begin
            et = IDLE; ed = '0;
            if (k >= 4 && k <= 6) begin
                et = (k == 6) ? DONE : VALID; ed = s[k-4];
            end
            n_vec++;
            if (ct !== et || wd !== ed || ce !== (et != IDLE)) begin
                n_err++;
                $display("FAIL basic_bus k=%0d: got type=%0d wdat=%h clk_en=%b want type=%0d wdat=%h",
                         k, ct, wd, ce, et, ed);
            end
            if (k == 3 || k == 4) begin
                n_vec++;
                if (txn_pending !== ((k == 3) ? 1 : 0)) begin
                    n_err++; $display("FAIL basic_pending k=%0d: got %0d", k, txn_pending);
                end
            end
            in_valid = (k < 3);
            in_data  = (k < 3) ? s[k % 3] : '0;
            in_last  = (k == 2);
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        logic [HW-1:0] b;
        logic [3:0]    et;
        logic [HW-1:0] ed;
        b = rnd();
        for (int k = 0; k < 5; k++) begin
            et = (k == 2) ? DONE : IDLE;
            ed = (k == 2) ? b : '0;
            n_vec++;
            if (ct !== et || wd !== ed || ce !== (et != IDLE)) begin
                n_err++;
                $display("FAIL single_bus k=%0d: got type=%0d wdat=%h clk_en=%b want type=%0d wdat=%h",
                         k, ct, wd, ce, et, ed);
            end
            in_valid = (k == 0);
            in_data  = (k == 0) ? b : '0;
            in_last  = (k == 0);
            @(negedge clk);
        end
    endtask

    // 4-beat E keeps the FSM busy while 2-beat C and D both complete behind it.
    task automatic test_back_to_back();
        logic [HW-1:0] s [8];
        logic          l [8];
        logic [3:0]    et;
        logic [HW-1:0] ed;
        int            ep;
        l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) s[i] = rnd();
        for (int k = 0; k < 14; k++) begin
            et = IDLE; ed = '0;
            if (k >= 5 && k <= 12) begin
                et = l[k-5] ? DONE : VALID; ed = s[k-5];
            end
            n_vec++;
            if (ct !== et || wd !== ed || ce !== (et != IDLE)) begin
                n_err++;
                $display("FAIL b2b_bus k=%0d: got type=%0d wdat=%h clk_en=%b want type=%0d wdat=%h",
                         k, ct, wd, ce, et, ed);
            end
            if (k >= 8 && k <= 11) begin
                ep = (k == 8) ? 2 : (k == 11) ? 0 : 1;
                n_vec++;
                if (txn_pending !== ep) begin
                    n_err++; $display("FAIL b2b_pending k=%0d: got %0d want %0d", k, txn_pending, ep);
                end
            end
            if (k < 8) begin
                n_vec++;
                if (in_ready !== 1'b1) begin
                    n_err++; $display("FAIL b2b_ready k=%0d: got %b want 1", k, in_ready);
                end
            end
            in_valid = (k < 8);
            in_data  = (k < 8) ? s[k % 8] : '0;
            in_last  = (k < 8) ? l[k % 8] : 1'b0;
            @(negedge clk);
        end
    endtask

    // Nine last-less beats then a closing beat: the first eight get truncated into one burst.
    task automatic test_truncation();
        logic [HW-1:0] t [10];
        logic [3:0]    et;
        logic [HW-1:0] ed;
        logic          er;
        logic          ee;
        logic          acc;
        int            idx;
        idx = 0;
        for (int i = 0; i < 10; i++) t[i] = rnd();
        for (int k = 0; k < 23; k++) begin
            et = IDLE; ed = '0;
            if (k >= 10 && k <= 16) begin
                et = VALID; ed = t[k-10];
            end else if (k == 17 || k == 19) begin
                et = DONE; ed = t[k-10];
            end else if (k == 18) begin
                et = VALID; ed = t[8];
            end
            n_vec++;
            if (ct !== et || wd !== ed || ce !== (et != IDLE)) begin
                n_err++;
                $display("FAIL trunc_bus k=%0d: got type=%0d wdat=%h clk_en=%b want type=%0d wdat=%h",
                         k, ct, wd, ce, et, ed);
            end
            er = !(k == 8 || k == 9);
            n_vec++;
            if (in_ready !== er) begin
                n_err++; $display("FAIL trunc_ready k=%0d: got %b want %b", k, in_ready, er);
            end
            ee = (k >= 9 && k <= 21);
            n_vec++;
            if (trunc_err !== ee) begin
                n_err++; $display("FAIL trunc_err_flag k=%0d: got %b want %b", k, trunc_err, ee);
            end
            if (k == 9 || k == 10 || k == 12) begin
                n_vec++;
                if (txn_pending !== ((k == 10) ? 0 : 1)) begin
                    n_err++; $display("FAIL trunc_pending k=%0d: got %0d", k, txn_pending);
                end
            end
            in_valid = (idx < 10);
            in_data  = (idx < 10) ? t[idx % 10] : '0;
            in_last  = (idx == 9);
            clr_err  = (k == 21);
            acc      = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        n_vec++;
        if (idx != 10) begin
            n_err++; $display("FAIL trunc_accepted: got %0d beats want 10", idx);
        end
    endtask

    // Reset lands while F0 is on the bus with G still queued; only H may appear afterwards.
    task automatic test_mid_reset();
        logic [HW-1:0] s [7];
        logic          l [7];
        logic [3:0]    et;
        logic [HW-1:0] ed;
        int            si;
        l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) s[i] = rnd();
        for (int k = 0; k < 14; k++) begin
            et = IDLE; ed = '0;
            if (k == 5) begin
                et = VALID; ed = s[0];
            end else if (k == 11) begin
                et = VALID; ed = s[5];
            end else if (k == 12) begin
                et = DONE; ed = s[6];
            end
            n_vec++;
            if (ct !== et || wd !== ed || ce !== (et != IDLE)) begin
                n_err++;
                $display("FAIL rst_bus k=%0d: got type=%0d wdat=%h clk_en=%b want type=%0d wdat=%h",
                         k, ct, wd, ce, et, ed);
            end
            if (k == 5 || k == 6 || k == 10) begin
                n_vec++;
                if (txn_pending !== ((k == 6) ? 0 : 1)) begin
                    n_err++; $display("FAIL rst_pending k=%0d: got %0d", k, txn_pending);
                end
            end
            if (k == 6 || k == 7 || k == 8) begin
                n_vec++;
                if (in_ready !== (k == 8)) begin
                    n_err++; $display("FAIL rst_ready k=%0d: got %b", k, in_ready);
                end
            end
            rst_n    = !(k == 5 || k == 6);
            si       = (k < 5) ? k : (k == 8) ? 5 : (k == 9) ? 6 : -1;
            in_valid = (si >= 0);
            in_data  = (si >= 0) ? s[si] : '0;
            in_last  = (si >= 0) ? l[si] : 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [HW:0] q [$];
        logic [HW:0] e;
        int          sent;
        int          rem;
        int          cyc;
        bit          in_txn;
        bit          acc;
        sent = 0; rem = 0; cyc = 0; in_txn = 0; acc = 0;
        in_valid = 1'b0;
        while (cyc < 60000 && (sent < 10000 || rem != 0 || in_valid || q.size() != 0)) begin
            if (acc) begin
                q.push_back({in_data, in_last});
                in_valid = 1'b0;
            end
            n_vec++;
            if (ct > DONE) begin
                n_err++; $display("FAIL rand_code cyc=%0d: got type=%0d want <=2", cyc, ct);
            end else if (ct == IDLE) begin
                if (ce !== 1'b0 || wd !== '0 || in_txn) begin
                    n_err++;
                    $display("FAIL rand_idle cyc=%0d: got clk_en=%b wdat=%h in_txn=%0d want 0,0,0",
                             cyc, ce, wd, in_txn);
                end
            end else begin
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rand_extra cyc=%0d: got beat %h want none", cyc, wd);
                end else begin
                    e = q.pop_front();
                    if (ce !== 1'b1 || wd !== e[HW:1] || (ct == DONE) !== e[0]) begin
                        n_err++;
                        $display("FAIL rand_beat cyc=%0d: got type=%0d wdat=%h clk_en=%b want wdat=%h last=%b",
                                 cyc, ct, wd, ce, e[HW:1], e[0]);
                    end
                end
                in_txn = (ct == VALID);
            end
            if (!in_valid && (sent < 10000 || rem != 0) && $urandom_range(0, 99) < 70) begin
                if (rem == 0) rem = $urandom_range(1, 8);
                in_data  = rnd();
                in_last  = (rem == 1);
                rem--;
                sent++;
                in_valid = 1'b1;
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc >= 60000) begin
            n_err++; $display("FAIL rand_timeout: got %0d cycles, queue %0d want drained", cyc, q.size());
        end
        n_vec++;
        if (trunc_err !== 1'b0) begin
            n_err++; $display("FAIL rand_trunc_err: got %b want 0", trunc_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_back_to_back();
        test_truncation();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hero_write_packer.md
Name: hero_write_packer

Overview:
- Upstream producer for the hero write bus.
- Accepts write-data beats over a valid/ready stream with a `last` marker and buffers each transaction in a small FIFO.
- Each transaction is store-and-forward: it is released only once its final beat is buffered.
- Drives the transaction as a contiguous `hero_write` sequence: zero or more VALID cycles, then exactly one DONE cycle, so the hero bus never sees a mid-transaction bubble.

Parameters:
- HERO_WIDTH, 36, width of the data field `wdat`.
- DEPTH, 8, FIFO depth in beats; also the maximum transaction length. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  sole clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block can accept a beat
- in_data  input  HERO_WIDTH  beat payload
- in_last  input  1  beat is the final beat of its transaction
- hero_out  output  hero_write (4+HERO_WIDTH+1=41)  registered bus: cycle_type, wdat, clk_en
- txn_pending  output  $clog2(DEPTH)+1  count of complete transactions buffered but not yet started
- trunc_err  output  1  sticky: a transaction was force-truncated
- clr_err  input  1  clears trunc_err

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; everything samples at the clk rising edge.
- Reset values: all outputs and state cleared in the cycle after the edge that samples rst_n=0.
  - hero_out.cycle_type=IDLE (0), wdat=0, clk_en=0; in_ready=0 while rst_n=0, 1 the cycle after reset is released.
  - FIFO empty, txn_pending=0, trunc_err=0, FSM in S_IDLE.
- Reset mid-transaction: the bus drops to IDLE with no DONE issued and buffered data is discarded. Downstream is reset on the same rst_n.
- Input handshake:
  - A beat transfers when in_valid && in_ready.
  - in_ready = !full, with no same-cycle pop bypass; a full FIFO refuses a beat even if a pop occurs that cycle.
  - Each stored entry holds {data, last}.
- Completion tracking:
  - A transfer with in_last=1 increments txn_pending at the next edge.
  - The FSM starting a transaction decrements it.
  - Simultaneous increment and decrement leaves it unchanged.
- Truncation:
  - Trigger: the FIFO becomes full while txn_pending=0, meaning no buffered last beat and deadlock imminent.
  - Action: the newest stored entry's last bit is forced to 1, txn_pending increments, and trunc_err sets.
  - Following upstream beats form a new transaction.
  - trunc_err clears only on clr_err=1. If clr_err and a new truncation occur in the same cycle, set wins.
- FSM:
  - S_IDLE: if txn_pending>0, pop the head beat and drive it. cycle_type is DONE if its last=1, else VALID. Go to S_SEND unless DONE. Otherwise drive IDLE.
  - S_SEND: pop every cycle. last=0 → VALID; last=1 → DONE, then act as S_IDLE in the following cycle.
  - Back-to-back: when txn_pending>0 at DONE, the next transaction's first beat is driven in the very next cycle with no IDLE gap.
  - A started transaction never starves, because all its beats are already buffered.
- Output encoding:
  - hero_out.clk_en = 1 whenever cycle_type ≠ IDLE.
  - wdat = popped data on VALID/DONE cycles, 0 on IDLE cycles.
  - cycle_type encodes IDLE=0, VALID=1, DONE=2; codes 3–15 are never driven.
- Latency: a last-beat handshake at cycle t with the FSM idle and FIFO otherwise empty makes the first bus beat visible at cycle t+2.
- Throughput: 1 beat/cycle sustained in and out.
- Pointers: wrap modulo DEPTH. Occupancy is 0..DEPTH; full = occupancy==DEPTH.

Test Plan:
- Reset, then 3-beat transaction A0,A1,A2 (last on A2) at cycles 0–2 → bus IDLE through cycle 3; VALID A0 at cycle 4, VALID A1 at 5, DONE A2 at 6, IDLE at 7; clk_en=1 only in cycles 4–6.
- Single-beat transaction B0 with in_last=1 → exactly one DONE cycle, wdat=B0, no VALID cycle.
- Two 2-beat transactions both buffered before the first starts → bus shows VALID,DONE,VALID,DONE contiguously; txn_pending goes 2→1→0.
- 9 beats with no last, DEPTH=8 → in_ready=0 after 8 beats; trunc_err=1; bus emits 7 VALID plus DONE on beat 8; beat 9 is accepted afterward as the start of a new transaction; clr_err pulse → trunc_err=0.
- Assert rst_n=0 during the VALID cycle of a 4-beat transaction → next cycle bus IDLE, clk_en=0, txn_pending=0; after release, new traffic starts from an empty FIFO.
- Random valid gaps, 1–8 beat transactions, 10k beats → scoreboard data order matches; every transaction is a VALID* DONE sequence with no IDLE inside it; cycle_type never exceeds 2.
